systolic_input_skewer: RTL and testbench

- Upstream feeder for the weight-stationary systolic array.
- Accepts one N-lane activation vector per beat on a valid/ready stream and emits the diagonal wavefront the array expects: lane i is delayed by i cycles relative to lane 0, with a matching per-row valid.
- Frames work into tiles delimited by s_last, drains the wavefront, then signals tile completion to the controller.

---
 rtl/npu_pkg.sv | 34 +++
 rtl/skew_delay_line.sv | 39 +++
 rtl/systolic_input_skewer.sv | 132 +++++++++++++
 tb/tb_systolic_input_skewer.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/npu_pkg.sv
// Shared NPU definitions: default array geometry, the input-skewer FSM
// encoding and a small elaboration-time log2 helper.
package npu_pkg;

    // Default array geometry shared by the skewer, systolic_array and mac_pe.
    localparam int NPU_N          = 4;
    localparam int NPU_DATA_WIDTH = 8;

    // Input-skewer FSM encodings, kept as named constants so other blocks
    // (e.g. debug taps in the controller) can decode the state.
    localparam logic [1:0] SKEW_IDLE_ENC   = 2'd0;
    localparam logic [1:0] SKEW_STREAM_ENC = 2'd1;
    localparam logic [1:0] SKEW_DRAIN_ENC  = 2'd2;

    typedef enum logic [1:0] {
        SKEW_IDLE   = SKEW_IDLE_ENC,
        SKEW_STREAM = SKEW_STREAM_ENC,
        SKEW_DRAIN  = SKEW_DRAIN_ENC
    } skewState_e;

    // Ceiling log2; returns 0 for values of 0 or 1.
    function automatic int clog2(input int value);
        int result;
        int remaining;
        result    = 0;
        remaining = value - 1;
        while (remaining > 0) begin
            result++;
            remaining = remaining >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/skew_delay_line.sv
// Fixed-depth shift register carrying one lane of data plus its valid flag.
// The output is the last stage, so a value written at edge t appears on
// the output during cycle t+DEPTH-1.
module skew_delay_line #(
    parameter int DEPTH = 1,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             clear_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             valid_i,
    output logic [WIDTH-1:0] data_o,
    output logic             valid_o
);

    logic [WIDTH-1:0] data_q [DEPTH];
    logic [DEPTH-1:0] valid_q;

    // Shift every stage by one each edge; clear wipes all in-flight entries.
    always_ff @(posedge clk) begin
        if (clear_i) begin
            for (int k = 0; k < DEPTH; k++) begin
                data_q[k] <= '0;
            end
            valid_q <= '0;
        end else begin
            data_q[0]  <= data_i;
            valid_q[0] <= valid_i;
            for (int k = 1; k < DEPTH; k++) begin
                data_q[k]  <= data_q[k-1];
                valid_q[k] <= valid_q[k-1];
            end
        end
    end

    assign data_o  = data_q[DEPTH-1];
    assign valid_o = valid_q[DEPTH-1];

endmodule

// File: rtl/systolic_input_skewer.sv
// Upstream feeder for the weight-stationary systolic array: turns one
// N-lane activation vector per beat into a diagonal wavefront (lane i
// delayed by i cycles), frames beats into tiles and reports completion
// once the last element of a tile has left on lane N-1.
module systolic_input_skewer
    import npu_pkg::*;
#(
    parameter int N          = NPU_N,
    parameter int DATA_WIDTH = NPU_DATA_WIDTH,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic [N*DATA_WIDTH-1:0] s_data,
    input  logic                    s_last,
    output logic [N*DATA_WIDTH-1:0] x_out,
    output logic [N-1:0]            valid_out,
    output logic                    busy,
    output logic                    tile_done,
    output logic [CNT_WIDTH-1:0]    tile_beats
);

    // Drain counter needs to hold N-1; keep at least one bit so N=1 works.
    localparam int DCW = (clog2(N) < 1) ? 1 : clog2(N);
    localparam logic [DCW-1:0]       DRAIN_LOAD = DCW'(N - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX    = '1;

    skewState_e           state_q, state_d;
    logic [DCW-1:0]       drainCnt_q, drainCnt_d;
    logic [CNT_WIDTH-1:0] beatCnt_q, beatCnt_d;
    logic [CNT_WIDTH-1:0] tileBeats_q, tileBeats_d;
    logic [CNT_WIDTH-1:0] beatInc;

    logic clearAll;
    logic accept;
    logic lastAccept;

    assign clearAll   = rst || flush;
    assign s_ready    = !clearAll && (state_q != SKEW_DRAIN);
    assign accept     = s_valid && s_ready;
    assign lastAccept = accept && s_last;
    assign beatInc    = (beatCnt_q == CNT_MAX) ? CNT_MAX : beatCnt_q + 1'b1;

    // Tile framing: IDLE waits for a first beat, STREAM runs until s_last,
    // DRAIN blocks input until the final wavefront element reaches lane N-1.
    always_comb begin
        state_d    = state_q;
        drainCnt_d = drainCnt_q;
        case (state_q)
            SKEW_IDLE: begin
                if (lastAccept) begin
                    state_d    = SKEW_DRAIN;
                    drainCnt_d = DRAIN_LOAD;
                end else if (accept) begin
                    state_d = SKEW_STREAM;
                end
            end
            SKEW_STREAM: begin
                if (lastAccept) begin
                    state_d    = SKEW_DRAIN;
                    drainCnt_d = DRAIN_LOAD;
                end
            end
            SKEW_DRAIN: begin
                if (drainCnt_q == '0) begin
                    state_d = SKEW_IDLE;
                end else begin
                    drainCnt_d = drainCnt_q - 1'b1;
                end
            end
            default: begin
                state_d = SKEW_IDLE;
            end
        endcase
    end

    // Beat accounting: saturating count of accepts, latched into tile_beats
    // on the closing beat so the controller sees a stable per-tile total.
    always_comb begin
        beatCnt_d   = beatCnt_q;
        tileBeats_d = tileBeats_q;
        if (lastAccept) begin
            tileBeats_d = beatInc;
            beatCnt_d   = '0;
        end else if (accept) begin
            beatCnt_d = beatInc;
        end
    end

    // State and counter registers; flush discards a tile exactly like reset.
    always_ff @(posedge clk) begin
        if (clearAll) begin
            state_q     <= SKEW_IDLE;
            drainCnt_q  <= '0;
            beatCnt_q   <= '0;
            tileBeats_q <= '0;
        end else begin
            state_q     <= state_d;
            drainCnt_q  <= drainCnt_d;
            beatCnt_q   <= beatCnt_d;
            tileBeats_q <= tileBeats_d;
        end
    end

    assign busy       = (state_q != SKEW_IDLE);
    assign tile_done  = (state_q == SKEW_DRAIN) && (drainCnt_q == '0);
    assign tile_beats = tileBeats_q;

    // One delay line per lane, depth i+1; non-accept edges inject a zero
    // bubble so valid_out marks exactly the cycles carrying real data.
    for (genvar i = 0; i < N; i++) begin : gLane
        logic [DATA_WIDTH-1:0] laneIn;

        assign laneIn = accept ? s_data[i*DATA_WIDTH +: DATA_WIDTH] : '0;

        skew_delay_line #(
            .DEPTH(i + 1),
            .WIDTH(DATA_WIDTH)
        ) uLane (
            .clk    (clk),
            .clear_i(clearAll),
            .data_i (laneIn),
            .valid_i(accept),
            .data_o (x_out[i*DATA_WIDTH +: DATA_WIDTH]),
            .valid_o(valid_out[i])
        );
    end

endmodule

// File: tb/tb_systolic_input_skewer.sv
// Self-checking bench for systolic_input_skewer: directed tile scenarios
// followed by randomized tiles, compared against a timeline model.
module tb_systolic_input_skewer;

    localparam int N   = 4;
    localparam int DW  = 8;
    localparam int CW  = 16;
    localparam int HIST = 8192;

    logic              clk;
    logic              rst;
    logic              flush;
    logic              sValid;
    logic              sReady;
    logic [N*DW-1:0]   sData;
    logic              sLast;
    logic [N*DW-1:0]   xOut;
    logic [N-1:0]      validOut;
    logic              busy;
    logic              tileDone;
    logic [CW-1:0]     tileBeats;

    int assertCount = 0;
    int failCount   = 0;

    // Model: what was accepted at each edge, plus tile timeline markers.
    logic [N*DW-1:0] histData  [HIST];
    bit              histValid [HIST];
    int              edgeNo     = 0;
    int              clearEdge  = -1;
    int              lastT      = -1000;
    bit              tileOpen   = 0;
    int              beatCount  = 0;
    int              beatsModel = 0;

    systolic_input_skewer #(
        .N(N),
        .DATA_WIDTH(DW),
        .CNT_WIDTH(CW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .s_valid   (sValid),
        .s_ready   (sReady),
        .s_data    (sData),
        .s_last    (sLast),
        .x_out     (xOut),
        .valid_out (validOut),
        .busy      (busy),
        .tile_done (tileDone),
        .tile_beats(tileBeats)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assertCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Compare every output against the model for the current cycle.
    task automatic checkOutput();
        for (int i = 0; i < N; i++) begin
            int e;
            logic [DW-1:0] expD;
            logic          expV;
            e    = edgeNo - i;
            expD = '0;
            expV = 1'b0;
            if (e >= 0 && e > clearEdge && histValid[e]) begin
                expD = histData[e][i*DW +: DW];
                expV = 1'b1;
            end
            check($sformatf("xOut[%0d]@%0d", i, edgeNo), 32'(xOut[i*DW +: DW]), 32'(expD));
            check($sformatf("validOut[%0d]@%0d", i, edgeNo), 32'(validOut[i]), 32'(expV));
        end
        check($sformatf("tileDone@%0d", edgeNo), 32'(tileDone), 32'(edgeNo == lastT + N - 1));
        check($sformatf("busy@%0d", edgeNo), 32'(busy),
              32'(tileOpen || (edgeNo >= lastT && edgeNo <= lastT + N - 1)));
        check($sformatf("tileBeats@%0d", edgeNo), 32'(tileBeats), 32'(beatsModel));
    endtask

    // Drive one cycle of inputs, check s_ready, clock it, update the model
    // and check the resulting outputs.
    task automatic applyStimulus(input bit r, input bit f, input bit v,
                                 input logic [N*DW-1:0] d, input bit l, output bit acc);
        bit readyExp;
        int e;
        rst    = r;
        flush  = f;
        sValid = v;
        sData  = d;
        sLast  = l;
        readyExp = !r && !f && (edgeNo >= lastT + N);
        #1;
        check($sformatf("sReady@%0d", edgeNo), 32'(sReady), 32'(readyExp));
        acc = v && readyExp;
        @(posedge clk);
        edgeNo++;
        e = edgeNo;
        if (e < HIST) begin
            histValid[e] = 1'b0;
            histData[e]  = '0;
        end
        if (r || f) begin
            clearEdge  = e;
            lastT      = -1000;
            tileOpen   = 0;
            beatCount  = 0;
            beatsModel = 0;
        end else if (acc) begin
            if (e < HIST) begin
                histValid[e] = 1'b1;
                histData[e]  = d;
            end
            beatCount++;
            if (l) begin
                beatsModel = beatCount;
                beatCount  = 0;
                lastT      = e;
                tileOpen   = 0;
            end else begin
                tileOpen = 1;
            end
        end
        #1;
        checkOutput();
    endtask

    function automatic logic [N*DW-1:0] pattern(input int b);
        logic [N*DW-1:0] v;
        for (int i = 0; i < N; i++) begin
            v[i*DW +: DW] = DW'(16 * b + i);
        end
        return v;
    endfunction

    initial begin
        bit acc;
        rst = 1'b1; flush = 1'b0; sValid = 1'b0; sData = '0; sLast = 1'b0;

        // Reset held for three edges, then idle.
        for (int k = 0; k < 3; k++) applyStimulus(1, 0, 0, '0, 0, acc);
        applyStimulus(0, 0, 0, '0, 0, acc);

        // Four-beat tile with back-to-back beats, then drain.
        for (int b = 0; b < 4; b++) applyStimulus(0, 0, 1, pattern(b), b == 3, acc);
        for (int k = 0; k < 5; k++) applyStimulus(0, 0, 0, '0, 0, acc);

        // Bubble in the middle of a tile; s_last noise on the bubble is ignored.
        applyStimulus(0, 0, 1, pattern(0), 0, acc);
        applyStimulus(0, 0, 0, pattern(9), 1, acc);
        applyStimulus(0, 0, 1, pattern(1), 0, acc);
        applyStimulus(0, 0, 1, pattern(2), 1, acc);
        for (int k = 0; k < 5; k++) applyStimulus(0, 0, 0, '0, 0, acc);

        // Single-beat tile with s_valid held through the drain.
        applyStimulus(0, 0, 1, pattern(5), 1, acc);
        for (int k = 0; k < 3; k++) applyStimulus(0, 0, 1, pattern(6 + k), 1, acc);
        applyStimulus(0, 0, 0, '0, 0, acc);
        for (int k = 0; k < 4; k++) applyStimulus(0, 0, 0, '0, 0, acc);

        // Flush mid-tile (with s_valid high), then a clean two-beat tile.
        applyStimulus(0, 0, 1, pattern(1), 0, acc);
        applyStimulus(0, 0, 1, pattern(2), 0, acc);
        applyStimulus(0, 1, 1, pattern(3), 0, acc);
        applyStimulus(0, 0, 1, pattern(4), 0, acc);
        applyStimulus(0, 0, 1, pattern(5), 1, acc);
        for (int k = 0; k < 5; k++) applyStimulus(0, 0, 0, '0, 0, acc);

        // Back-to-back three-beat tiles with s_valid held high throughout.
        for (int t = 0; t < 2; t++) begin
            int b;
            int guard;
            b = 0;
            guard = 0;
            while (b < 3 && guard < 50) begin
                applyStimulus(0, 0, 1, pattern(b + 4 * t), b == 2, acc);
                if (acc) b++;
                guard++;
            end
            if (b < 3) begin
                assertCount++;
                failCount++;
                $error("FAIL backToBackGuard observed=%0d expected=3", b);
            end
        end
        for (int k = 0; k < 5; k++) applyStimulus(0, 0, 0, '0, 0, acc);

        // Randomized tiles: random lengths, bubbles, data and rare flushes.
        for (int t = 0; t < 25; t++) begin
            int len;
            int b;
            int guard;
            len = int'($urandom_range(1, 6));
            b = 0;
            guard = 0;
            while (b < len && guard < 200) begin
                bit v;
                bit l;
                logic [N*DW-1:0] d;
                d = N*DW'($urandom);
                if ($urandom_range(0, 39) == 0) begin
                    applyStimulus(0, 1, 1, d, 0, acc);
                    b = len;
                end else begin
                    v = ($urandom_range(0, 3) != 0);
                    l = v ? (b == len - 1) : 1'($urandom_range(0, 1));
                    applyStimulus(0, 0, v, d, l, acc);
                    if (acc) b++;
                end
                guard++;
            end
            if (b < len) begin
                assertCount++;
                failCount++;
                $error("FAIL randomTileGuard observed=%0d expected=%0d", b, len);
            end
        end
        for (int k = 0; k < 6; k++) applyStimulus(0, 0, 0, '0, 0, acc);

        $display("[TB] End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
